// File: rtl/sobel_pkg.sv
// Shared widths and helpers for the Sobel edge-detection stage of the
// Gray_Sobel_Erosion path.
package sobel_pkg;

  localparam int PIX_W      = 8;
  localparam int GRAD_W     = 10;
  localparam int MAG_W      = 11;
  localparam int LINE_CNT_W = 11;
  localparam int SYNC_DLY   = 5;

  typedef struct packed {
    logic vsync;
    logic href;
    logic clken;
    logic hsync;
  } sync_t;

  function automatic logic [GRAD_W-1:0] abs_diff(input logic [GRAD_W-1:0] a,
                                                 input logic [GRAD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sobel_linebuf.sv
// Clock-enabled delay line: dout is the sample written DEPTH enables ago.
// Storage is not reset; only the pointer is.
module sobel_linebuf
  import sobel_pkg::*;
#(
  parameter int DEPTH = 640
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en) ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  // Read-before-write at the same slot yields the sample from DEPTH enables ago.
  always_ff @(posedge clk) begin
    if (en) mem_q[ptr_q] <= din;
  end

  assign dout = mem_q[ptr_q];

endmodule

// File: rtl/sobel_edge_detector.sv
// 3x3 Sobel |Gx|+|Gy| on the luma stream with thresholded edge flag;
// five-stage data pipeline kept in step with a five-deep sync delay line.
module sobel_edge_detector
  import sobel_pkg::*;
#(
  parameter int IMG_HDISP = 640
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  per_frame_vsync,
  input  logic                  per_frame_href,
  input  logic                  per_frame_clken,
  input  logic                  per_frame_hsync,
  input  logic [PIX_W-1:0]      per_img_Y,
  input  logic [MAG_W-1:0]      sobel_threshold,
  output logic                  post_frame_vsync,
  output logic                  post_frame_href,
  output logic                  post_frame_clken,
  output logic                  post_frame_hsync,
  output logic [PIX_W-1:0]      post_img_mag,
  output logic                  post_img_bit
);

  sync_t                       sync_in;
  sync_t [SYNC_DLY-1:0]        sync_q, sync_d;
  logic                        href_prev_q, href_prev_d;
  logic                        vsync_prev_q, vsync_prev_d;
  logic [LINE_CNT_W-1:0]       col_cnt_q, col_cnt_d;
  logic [LINE_CNT_W-1:0]       line_cnt_q, line_cnt_d;
  logic [PIX_W-1:0]            tap1, tap2;
  logic [2:0][2:0][PIX_W-1:0]  win_q, win_d;
  logic                        val1_q, val1_d, val2_q, val2_d;
  logic                        val3_q, val3_d, val4_q, val4_d;
  logic [GRAD_W-1:0]           pp_q, pp_d, pn_q, pn_d, qp_q, qp_d, qn_q, qn_d;
  logic [GRAD_W-1:0]           gx_q, gx_d, gy_q, gy_d;
  logic [MAG_W-1:0]            g_q, g_d;
  logic [PIX_W-1:0]            mag_q, mag_d;
  logic                        edge_q, edge_d;
  logic                        accept, href_fall, vsync_rise;

  assign sync_in    = {per_frame_vsync, per_frame_href, per_frame_clken, per_frame_hsync};
  assign accept     = per_frame_href & per_frame_clken;
  assign href_fall  = href_prev_q & ~per_frame_href;
  assign vsync_rise = per_frame_vsync & ~vsync_prev_q;

  sobel_linebuf #(.DEPTH(IMG_HDISP)) u_lb0 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (accept),
    .din  (per_img_Y),
    .dout (tap1)
  );

  sobel_linebuf #(.DEPTH(IMG_HDISP)) u_lb1 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (accept),
    .din  (tap1),
    .dout (tap2)
  );

  always_comb begin
    sync_d       = {sync_q[SYNC_DLY-2:0], sync_in};
    href_prev_d  = per_frame_href;
    vsync_prev_d = per_frame_vsync;

    col_cnt_d = col_cnt_q;
    if (href_fall)                     col_cnt_d = '0;
    else if (accept && col_cnt_q != '1) col_cnt_d = col_cnt_q + 1'b1;

    line_cnt_d = line_cnt_q;
    if (vsync_rise)                          line_cnt_d = '0;
    else if (href_fall && line_cnt_q != '1)  line_cnt_d = line_cnt_q + 1'b1;

    // Row 0 is the oldest line, column 2 the newest pixel.
    win_d  = win_q;
    val1_d = val1_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = tap2;
      win_d[1][2] = tap1;
      win_d[2][2] = per_img_Y;
      val1_d = (line_cnt_q >= LINE_CNT_W'(2)) && (col_cnt_q >= LINE_CNT_W'(2));
    end

    pp_d = GRAD_W'(win_q[0][2]) + (GRAD_W'(win_q[1][2]) << 1) + GRAD_W'(win_q[2][2]);
    pn_d = GRAD_W'(win_q[0][0]) + (GRAD_W'(win_q[1][0]) << 1) + GRAD_W'(win_q[2][0]);
    qp_d = GRAD_W'(win_q[2][0]) + (GRAD_W'(win_q[2][1]) << 1) + GRAD_W'(win_q[2][2]);
    qn_d = GRAD_W'(win_q[0][0]) + (GRAD_W'(win_q[0][1]) << 1) + GRAD_W'(win_q[0][2]);
    val2_d = val1_q;

    gx_d   = abs_diff(pp_q, pn_q);
    gy_d   = abs_diff(qp_q, qn_q);
    val3_d = val2_q;

    g_d    = MAG_W'(gx_q) + MAG_W'(gy_q);
    val4_d = val3_q;

    mag_d  = '0;
    if (val4_q) mag_d = (g_q > MAG_W'(255)) ? '1 : g_q[PIX_W-1:0];
    edge_d = val4_q && (g_q > sobel_threshold);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      href_prev_q  <= 1'b0;
      vsync_prev_q <= 1'b0;
      col_cnt_q    <= '0;
      line_cnt_q   <= '0;
      win_q        <= '0;
      val1_q       <= 1'b0;
      val2_q       <= 1'b0;
      val3_q       <= 1'b0;
      val4_q       <= 1'b0;
      pp_q         <= '0;
      pn_q         <= '0;
      qp_q         <= '0;
      qn_q         <= '0;
      gx_q         <= '0;
      gy_q         <= '0;
      g_q          <= '0;
      mag_q        <= '0;
      edge_q       <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      href_prev_q  <= href_prev_d;
      vsync_prev_q <= vsync_prev_d;
      col_cnt_q    <= col_cnt_d;
      line_cnt_q   <= line_cnt_d;
      win_q        <= win_d;
      val1_q       <= val1_d;
      val2_q       <= val2_d;
      val3_q       <= val3_d;
      val4_q       <= val4_d;
      pp_q         <= pp_d;
      pn_q         <= pn_d;
      qp_q         <= qp_d;
      qn_q         <= qn_d;
      gx_q         <= gx_d;
      gy_q         <= gy_d;
      g_q          <= g_d;
      mag_q        <= mag_d;
      edge_q       <= edge_d;
    end
  end

  assign post_frame_vsync = sync_q[SYNC_DLY-1].vsync;
  assign post_frame_href  = sync_q[SYNC_DLY-1].href;
  assign post_frame_clken = sync_q[SYNC_DLY-1].clken;
  assign post_frame_hsync = sync_q[SYNC_DLY-1].hsync;
  assign post_img_mag     = post_frame_href ? mag_q : '0;
  assign post_img_bit     = post_frame_href & edge_q;

endmodule

// File: doc/sobel_edge_detector.md
Name: sobel_edge_detector

Overview:
- Consumes the 8-bit luma stream (Y) from the RGB888-to-YCbCr444 stage in the Gray_Sobel_Erosion path.
- Builds a 3x3 neighbourhood with two line buffers and computes the Sobel gradient magnitude |Gx|+|Gy|.
- Thresholds the magnitude to a 1-bit edge map and passes it to the downstream erosion stage.
- Frame timing signals pass through with a fixed delay.

Parameters:
- IMG_HDISP, 640, active pixels per line; sets line-buffer depth.
- SYNC_DLY, 5, clk-cycle delay applied to vsync/href/hsync/clken; fixed by the pipeline, not user-tunable.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- per_frame_vsync  in  1  input vsync; active-high during the frame
- per_frame_href  in  1  input line-valid
- per_frame_clken  in  1  input pixel enable
- per_frame_hsync  in  1  input hsync
- per_img_Y  in  8  input luma
- sobel_threshold  in  11  edge threshold; quasi-static, sampled every cycle
- post_frame_vsync  out  1  delayed vsync
- post_frame_href  out  1  delayed href
- post_frame_clken  out  1  delayed clken
- post_frame_hsync  out  1  delayed hsync
- post_img_mag  out  8  gradient magnitude, saturated to 255
- post_img_bit  out  1  edge flag

Behaviour:
- Reset: clk, one clock domain; reset is asynchronous, active-low on rst_n.
  - All pipeline registers, counters, window registers and delay lines clear to 0; all outputs are 0.
  - Line-buffer storage need not clear.
- Window update:
  - On each cycle with per_frame_href && per_frame_clken, Y enters line buffer 0.
  - The pixel leaving buffer 0 (IMG_HDISP pixels earlier) enters buffer 1.
  - The three column taps (current, 1 line old, 2 lines old) shift into a 3x3 window register p[r][c].
  - Window and buffers hold when clken=0.
- Counters:
  - col_cnt increments on each accepted pixel and clears on the href falling edge.
  - line_cnt increments on the href falling edge, saturates at 2047, and clears on the vsync rising edge.
- Border: the window is valid only when line_cnt>=2 && col_cnt>=2, sampled at window load. When invalid, the magnitude is forced to 0 for that pixel.
- Geometry: output pixel (r,c) is the window centred on input (r-1,c-1), an inherent 1-line + 1-pixel spatial offset. There is no realignment.
- Arithmetic pipeline (advances every clk):
  - S1: window register load.
  - S2: Pp = p[0][2]+2p[1][2]+p[2][2] and Pn = p[0][0]+2p[1][0]+p[2][0]. Qp = p[2][0]+2p[2][1]+p[2][2] and Qn = p[0][0]+2p[0][1]+p[0][2]. All are 10-bit unsigned.
  - S3: |Gx| = |Pp-Pn| and |Gy| = |Qp-Qn|, each 10-bit.
  - S4: G = |Gx|+|Gy|, 11-bit, max 2040.
  - S5: post_img_bit = (G > sobel_threshold) && valid. post_img_mag = (G>255) ? 255 : G[7:0], then zeroed when invalid.
- Latency and gating:
  - Total latency is SYNC_DLY=5 clk from the input sample to the output.
  - Sync signals use 5-deep shift registers every clk.
  - post_img_mag and post_img_bit are gated to 0 when post_frame_href=0.
- Gapped clken: data at the output is meaningful only when post_frame_clken=1. The values held between enables are don't-care but must be stable.
- Short line (href falls before IMG_HDISP pixels): buffers keep stale pixels, and the next line's window uses them. This is not an error.
- Reset mid-frame: outputs go to 0 immediately. After release, line_cnt=0, so the first two lines after the next vsync rise are border (mag 0).
- vsync rising while href high: line_cnt clears anyway.

Decomposition:
- Package sobel_pkg: PIX_W=8, GRAD_W=10, MAG_W=11, LINE_CNT_W=11, SYNC_DLY=5.
- Sub-module sobel_linebuf: parameterised IMG_HDISP-deep, 8-bit, clock-enabled shift/RAM delay line. Instantiate twice.

Test Plan:
- Uniform frame, Y=100 everywhere, threshold=50, 640x8 -> post_img_mag=0 and post_img_bit=0 for every pixel.
- Vertical step, Y=0 for cols<320 and Y=255 for cols>=320, threshold=1000 -> rows>=2, output cols 320 and 321: G=1020, mag=255, bit=1. All other cols are 0.
- Same step with threshold=1020 -> bit=0 everywhere and mag unchanged. Threshold=1019 -> bit=1 at the step.
- Border check on a random frame -> output lines 0-1 and cols 0-1 of every line are mag=0 and bit=0. The first output pixel trails the input by exactly 5 clk.
- clken gapped 1-in-3 with the step image -> same mag/bit values at post_frame_clken cycles as the continuous run.
- rst_n pulsed low mid-line 4 -> all post_* are 0 while low. The next frame after the vsync rise matches the golden model.
